// File: rtl/port_rd_frontend.sv
// Egress read frontend for one output port: picks a priority queue, requests its head
// packet, buffers the returned words and replays them as sop / data / eop framing.
module port_rd_frontend #(
    parameter int FIFO_DEPTH   = 16,
    parameter int PAUSE_MARGIN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrr_enable,
    input  logic [7:0]  queue_empty,
    input  logic        ready,
    output logic        pop_request,
    output logic [2:0]  pop_prior,
    input  logic        pop_ack,
    input  logic        xfer_data_vld,
    input  logic [15:0] xfer_data,
    input  logic        xfer_end_of_packet,
    output logic        xfer_pause,
    output logic        rd_sop,
    output logic        rd_eop,
    output logic        rd_vld,
    output logic [15:0] rd_data,
    output logic        overflow_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_SOP, S_DATA, S_EOP} state_e;

    state_e        state_q, state_d;
    logic          pop_request_q, pop_request_d;
    logic [2:0]    pop_prior_q, pop_prior_d;
    logic [2:0]    rr_ptr_q, rr_ptr_d;
    logic          rd_sop_q, rd_sop_d;
    logic          rd_eop_q, rd_eop_d;
    logic          rd_vld_q, rd_vld_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          last_q, last_d;
    logic          xfer_pause_q, xfer_pause_d;
    logic          overflow_q, overflow_d;

    logic [16:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, push, pop;
    logic [16:0]   head;
    logic [2:0]    grant;

    assign full = (cnt_q == CW'(FIFO_DEPTH));
    assign push = xfer_data_vld && !full;
    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {xfer_end_of_packet, xfer_data};
    end

    // Scan from the base downwards so the smallest offset from the base wins.
    always_comb begin
        logic [2:0] base;
        logic [2:0] idx;
        base  = wrr_enable ? rr_ptr_q : 3'd0;
        idx   = 3'd0;
        grant = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = base + 3'(i);
            if (!queue_empty[idx]) grant = idx;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + (push ? AW'(1) : AW'(0));
        rd_ptr_d     = rd_ptr_q + (pop ? AW'(1) : AW'(0));
        cnt_d        = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        xfer_pause_d = (CW'(FIFO_DEPTH) - cnt_q) <= CW'(PAUSE_MARGIN);
        overflow_d   = overflow_q | (xfer_data_vld & full);
    end

    // last_q marks that the word currently on rd_data closes the packet; eop follows it.
    always_comb begin
        state_d       = state_q;
        pop_request_d = pop_request_q;
        pop_prior_d   = pop_prior_q;
        rr_ptr_d      = rr_ptr_q;
        rd_sop_d      = 1'b0;
        rd_eop_d      = 1'b0;
        rd_vld_d      = 1'b0;
        rd_data_d     = rd_data_q;
        last_d        = 1'b0;
        pop           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ready && queue_empty != 8'hFF) begin
                    pop_prior_d   = grant;
                    pop_request_d = 1'b1;
                    state_d       = S_REQ;
                end
            end
            S_REQ: begin
                if (pop_ack) begin
                    pop_request_d = 1'b0;
                    rd_sop_d      = 1'b1;
                    state_d       = S_SOP;
                    if (wrr_enable) rr_ptr_d = pop_prior_q + 3'd1;
                end
            end
            S_SOP, S_DATA: begin
                state_d = S_DATA;
                if (rd_vld_q && last_q) begin
                    rd_eop_d = 1'b1;
                    state_d  = S_EOP;
                end else if (cnt_q != '0) begin
                    pop       = 1'b1;
                    rd_vld_d  = 1'b1;
                    rd_data_d = head[15:0];
                    last_d    = head[16];
                end
            end
            S_EOP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pop_request_q <= 1'b0;
            pop_prior_q   <= 3'd0;
            rr_ptr_q      <= 3'd0;
            rd_sop_q      <= 1'b0;
            rd_eop_q      <= 1'b0;
            rd_vld_q      <= 1'b0;
            rd_data_q     <= 16'd0;
            last_q        <= 1'b0;
            xfer_pause_q  <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pop_request_q <= pop_request_d;
            pop_prior_q   <= pop_prior_d;
            rr_ptr_q      <= rr_ptr_d;
            rd_sop_q      <= rd_sop_d;
            rd_eop_q      <= rd_eop_d;
            rd_vld_q      <= rd_vld_d;
            rd_data_q     <= rd_data_d;
            last_q        <= last_d;
            xfer_pause_q  <= xfer_pause_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign pop_request  = pop_request_q;
    assign pop_prior    = pop_prior_q;
    assign rd_sop       = rd_sop_q;
    assign rd_eop       = rd_eop_q;
    assign rd_vld       = rd_vld_q;
    assign rd_data      = rd_data_q;
    assign xfer_pause   = xfer_pause_q;
    assign overflow_err = overflow_q;
endmodule

// File: tb/tb_port_rd_frontend.sv
// Directed bench for port_rd_frontend: a per-cycle vector table for the strict-priority
// packet flow, then hand sequences for WRR, gaps, overflow and mid-packet reset.
module tb_port_rd_frontend;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrr_enable = 1'b0;
    logic [7:0]  queue_empty = 8'hFF;
    logic        ready = 1'b0;
    logic        pop_ack = 1'b0;
    logic        xfer_data_vld = 1'b0;
    logic [15:0] xfer_data = 16'h0;
    logic        xfer_end_of_packet = 1'b0;
    logic        pop_request, xfer_pause, rd_sop, rd_eop, rd_vld, overflow_err;
    logic [2:0]  pop_prior;
    logic [15:0] rd_data;

    int n_vec = 0;
    int n_err = 0;

    port_rd_frontend #(.FIFO_DEPTH(16), .PAUSE_MARGIN(4)) dut (
        .clk(clk), .rst_n(rst_n), .wrr_enable(wrr_enable), .queue_empty(queue_empty),
        .ready(ready), .pop_request(pop_request), .pop_prior(pop_prior), .pop_ack(pop_ack),
        .xfer_data_vld(xfer_data_vld), .xfer_data(xfer_data),
        .xfer_end_of_packet(xfer_end_of_packet), .xfer_pause(xfer_pause),
        .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld), .rd_data(rd_data),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [7:0]  qe;
        logic        ack;
        logic        xv;
        logic [15:0] xd;
        logic        xe;
        logic        req;
        logic [2:0]  pri;
        logic        sop;
        logic        vld;
        logic [15:0] dat;
        logic        eop;
    } vec_t;

    function automatic vec_t v(logic rdy, logic [7:0] qe, logic ack, logic xv, logic [15:0] xd,
                               logic xe, logic req, logic [2:0] pri, logic sop, logic vld,
                               logic [15:0] dat, logic eop);
        vec_t r;
        r.rdy = rdy; r.qe = qe; r.ack = ack; r.xv = xv; r.xd = xd; r.xe = xe;
        r.req = req; r.pri = pri; r.sop = sop; r.vld = vld; r.dat = dat; r.eop = eop;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic idle_inputs();
        ready = 1'b0; queue_empty = 8'hFF; pop_ack = 1'b0;
        xfer_data_vld = 1'b0; xfer_data = 16'h0; xfer_end_of_packet = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_req();
        int t = 0;
        while (!pop_request && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("pop_request_seen", pop_request, 1);
    endtask

    // Words are delivered early (while the request is pending), then ack, then replay.
    task automatic serve(input logic [2:0] pri, input int nw, input logic [15:0] base);
        wait_req();
        chk("pop_prior", pop_prior, pri);
        for (int i = 0; i < nw; i++) begin
            xfer_data_vld = 1'b1; xfer_data = base + 16'(i); xfer_end_of_packet = (i == nw - 1);
            @(negedge clk);
        end
        xfer_data_vld = 1'b0; xfer_end_of_packet = 1'b0; pop_ack = 1'b1;
        @(negedge clk);
        pop_ack = 1'b0;
        chk("serve_sop", rd_sop, 1);
        for (int i = 0; i < nw; i++) begin
            @(negedge clk);
            chk("serve_vld", rd_vld, 1);
            chk("serve_data", rd_data, base + 16'(i));
        end
        @(negedge clk);
        chk("serve_eop", rd_eop, 1);
        chk("serve_vld_at_eop", rd_vld, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        // Idle gating, strict grant 1, basic 3-word packet, next strict grant 3.
        for (int i = 0; i < 4; i++) tbl.push_back(v(0, 8'h00, 0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0, 0));
        tbl.push_back(v(1, 8'hF5, 0, 0, 16'h0,    0, 0, 0, 0, 0, 16'h0,    0));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0, 8'hFF, 0, 0, 16'h0, 0, 1, 1, 0, 0, 16'h0, 0));
        tbl.push_back(v(0, 8'hFF, 0, 1, 16'hA001, 0, 1, 1, 0, 0, 16'h0,    0));
        tbl.push_back(v(0, 8'hFF, 1, 1, 16'hA002, 0, 1, 1, 0, 0, 16'h0,    0));
        tbl.push_back(v(0, 8'hFF, 0, 1, 16'hA003, 1, 0, 1, 1, 0, 16'h0,    0));
        tbl.push_back(v(1, 8'hF7, 0, 0, 16'h0,    0, 0, 1, 0, 1, 16'hA001, 0));
        tbl.push_back(v(1, 8'hF7, 0, 0, 16'h0,    0, 0, 1, 0, 1, 16'hA002, 0));
        tbl.push_back(v(1, 8'hF7, 0, 0, 16'h0,    0, 0, 1, 0, 1, 16'hA003, 0));
        tbl.push_back(v(1, 8'hF7, 0, 0, 16'h0,    0, 0, 1, 0, 0, 16'h0,    1));
        tbl.push_back(v(1, 8'hF7, 0, 0, 16'h0,    0, 0, 1, 0, 0, 16'h0,    0));
        tbl.push_back(v(1, 8'hF7, 0, 0, 16'h0,    0, 1, 3, 0, 0, 16'h0,    0));

        wrr_enable = 1'b0;
        do_reset();
        chk("reset_rd_data", rd_data, 16'h0);
        foreach (tbl[i]) begin
            chk("tbl_req", pop_request, tbl[i].req);
            chk("tbl_prior", pop_prior, tbl[i].pri);
            chk("tbl_sop", rd_sop, tbl[i].sop);
            chk("tbl_vld", rd_vld, tbl[i].vld);
            chk("tbl_eop", rd_eop, tbl[i].eop);
            chk("tbl_pause", xfer_pause, 0);
            chk("tbl_ovf", overflow_err, 0);
            if (tbl[i].vld) chk("tbl_data", rd_data, tbl[i].dat);
            ready = tbl[i].rdy; queue_empty = tbl[i].qe; pop_ack = tbl[i].ack;
            xfer_data_vld = tbl[i].xv; xfer_data = tbl[i].xd; xfer_end_of_packet = tbl[i].xe;
            @(negedge clk);
        end

        // WRR rotation 0,1,2; pointer then at 3; wrap from 4 back to 0.
        do_reset();
        wrr_enable = 1'b1; queue_empty = 8'h00; ready = 1'b1;
        serve(3'd0, 1, 16'hC000);
        serve(3'd1, 1, 16'hC100);
        serve(3'd2, 1, 16'hC200);
        queue_empty = 8'b1111_0110;
        serve(3'd3, 1, 16'hC300);
        queue_empty = 8'b1111_1110;
        serve(3'd0, 2, 16'hC400);

        // Gap: early first word, second word four cycles later.
        do_reset();
        wrr_enable = 1'b0; queue_empty = 8'hFE; ready = 1'b1;
        wait_req();
        xfer_data_vld = 1'b1; xfer_data = 16'hB001;
        @(negedge clk);
        xfer_data_vld = 1'b0; pop_ack = 1'b1;
        @(negedge clk);
        pop_ack = 1'b0;
        chk("gap_sop", rd_sop, 1);
        chk("gap_vld_at_sop", rd_vld, 0);
        @(negedge clk);
        chk("gap_vld1", rd_vld, 1);
        chk("gap_data1", rd_data, 16'hB001);
        @(negedge clk);
        chk("gap_hole1", rd_vld, 0);
        xfer_data_vld = 1'b1; xfer_data = 16'hB002; xfer_end_of_packet = 1'b1;
        @(negedge clk);
        xfer_data_vld = 1'b0; xfer_end_of_packet = 1'b0;
        chk("gap_hole2", rd_vld, 0);
        chk("gap_no_early_eop", rd_eop, 0);
        @(negedge clk);
        chk("gap_vld2", rd_vld, 1);
        chk("gap_data2", rd_data, 16'hB002);
        @(negedge clk);
        chk("gap_eop", rd_eop, 1);
        chk("gap_vld_at_eop", rd_vld, 0);
        @(negedge clk);
        chk("gap_eop_once", rd_eop, 0);
        chk("gap_no_dup", rd_vld, 0);

        // Backpressure, overflow, idle gating with ready low, then drain.
        do_reset();
        queue_empty = 8'h00; ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("bp_no_req", pop_request, 0);
            xfer_data_vld = 1'b1; xfer_data = 16'hD000 + 16'(i); xfer_end_of_packet = 1'b0;
            @(negedge clk);
        end
        xfer_data_vld = 1'b0;
        chk("pause_at_count12", xfer_pause, 0);
        @(negedge clk);
        chk("pause_after_count12", xfer_pause, 1);
        for (int i = 12; i < 17; i++) begin
            chk("ovf_before_drop", overflow_err, 0);
            xfer_data_vld = 1'b1; xfer_data = 16'hD000 + 16'(i); xfer_end_of_packet = (i >= 15);
            @(negedge clk);
        end
        xfer_data_vld = 1'b0; xfer_end_of_packet = 1'b0;
        chk("ovf_set", overflow_err, 1);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", overflow_err, 1);
        chk("bp_req_gated", pop_request, 0);
        ready = 1'b1; queue_empty = 8'hFE;
        wait_req();
        chk("drain_prior", pop_prior, 0);
        pop_ack = 1'b1;
        @(negedge clk);
        pop_ack = 1'b0;
        chk("drain_sop", rd_sop, 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("drain_vld", rd_vld, 1);
            chk("drain_data", rd_data, 16'hD000 + 16'(i));
        end
        @(negedge clk);
        chk("drain_eop", rd_eop, 1);
        chk("drain_pause_clear", xfer_pause, 0);
        chk("drain_ovf_still", overflow_err, 1);

        // Reset in mid-DATA: immediate clear, buffered words discarded, rr_ptr back to 0.
        do_reset();
        wrr_enable = 1'b1; queue_empty = 8'h00; ready = 1'b1;
        wait_req();
        chk("rst_prior", pop_prior, 0);
        for (int i = 0; i < 3; i++) begin
            xfer_data_vld = 1'b1; xfer_data = 16'hE000 + 16'(i);
            @(negedge clk);
        end
        xfer_data_vld = 1'b0; pop_ack = 1'b1;
        @(negedge clk);
        pop_ack = 1'b0;
        @(negedge clk);
        chk("rst_pre_vld", rd_vld, 1);
        chk("rst_pre_data", rd_data, 16'hE000);
        rst_n = 1'b0;
        #1;
        chk("async_vld", rd_vld, 0);
        chk("async_data", rd_data, 0);
        chk("async_sop", rd_sop, 0);
        chk("async_eop", rd_eop, 0);
        chk("async_req", pop_request, 0);
        chk("async_prior", pop_prior, 0);
        chk("async_pause", xfer_pause, 0);
        chk("async_ovf", overflow_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_req();
        chk("post_rst_prior", pop_prior, 0);
        pop_ack = 1'b1;
        @(negedge clk);
        pop_ack = 1'b0;
        chk("post_rst_sop", rd_sop, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_fifo_empty", rd_vld, 0);
        end
        xfer_data_vld = 1'b1; xfer_data = 16'hF00D; xfer_end_of_packet = 1'b1;
        @(negedge clk);
        xfer_data_vld = 1'b0; xfer_end_of_packet = 1'b0;
        chk("post_rst_wait", rd_vld, 0);
        @(negedge clk);
        chk("post_rst_vld", rd_vld, 1);
        chk("post_rst_data", rd_data, 16'hF00D);
        @(negedge clk);
        chk("post_rst_eop", rd_eop, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
